// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ==========================================================================
// mem_port_arbiter_if : one requester's view of the shared Memory data port
// Rev 1.0
// ==========================================================================
interface mem_port_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  rd_type;
  logic [1:0]  wr_type;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, rd_type, wr_type, input ack, rdata);
  modport slave  (input req, we, addr, wdata, rd_type, wr_type, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ==========================================================================
// mem_port_arbiter : two-requester arbiter for the single Memory data port
// Rev 1.0
// ==========================================================================
module mem_port_arbiter #(
  parameter int MEM_CYCLES = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  m0,
  mem_port_arbiter_if.slave  m1,
  output logic               mem_rd_en,
  output logic               mem_wr_en,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wr_data,
  output logic [2:0]         mem_rd_type,
  output logic [1:0]         mem_wr_type,
  input  logic [31:0]        mem_rd_data,
  output logic               busy
);

  localparam logic [3:0] C_CNT_INIT = 4'(MEM_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic        r_last_gnt;
  logic        r_sel;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_rd_type;
  logic [1:0]  r_wr_type;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;
  logic        w_any_req;
  logic        w_gnt;

  assign w_any_req = m0.req | m1.req;
  // On a tie: fixed priority favours m0, otherwise whoever was not served last
  assign w_gnt = (m0.req & m1.req) ? ((FIXED_PRIO != 0) ? 1'b0 : ~r_last_gnt) : m1.req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    mem_addr     = 32'd0;
    mem_wr_data  = 32'd0;
    mem_rd_type  = 3'd0;
    mem_wr_type  = 2'd0;
    m0.ack       = 1'b0;
    m1.ack       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_rd_en   = ~r_we;
        mem_wr_en   = r_we;
        mem_addr    = r_addr;
        mem_wr_data = r_wdata;
        mem_rd_type = r_rd_type;
        mem_wr_type = r_wr_type;
        if (r_cnt == 4'd0) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        m0.ack       = ~r_sel;
        m1.ack       = r_sel;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= 4'd0;
      r_last_gnt <= 1'b1;
      r_sel      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rd_type  <= 3'd0;
      r_wr_type  <= 2'd0;
      r_rdata0   <= 32'd0;
      r_rdata1   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel      <= w_gnt;
            r_last_gnt <= w_gnt;
            r_we       <= w_gnt ? m1.we      : m0.we;
            r_addr     <= w_gnt ? m1.addr    : m0.addr;
            r_wdata    <= w_gnt ? m1.wdata   : m0.wdata;
            r_rd_type  <= w_gnt ? m1.rd_type : m0.rd_type;
            r_wr_type  <= w_gnt ? m1.wr_type : m0.wr_type;
            r_cnt      <= C_CNT_INIT;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            // Memory read data is combinational, so the last access cycle has it
            if (!r_we) begin
              if (r_sel) begin
                r_rdata1 <= mem_rd_data;
              end else begin
                r_rdata0 <= mem_rd_data;
              end
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign m0.rdata = r_rdata0;
  assign m1.rdata = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_mem_port_arbiter : three arbiter configurations on one shared stimulus
// Rev 1.0
// ==========================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [2:0]  rdt0, rdt1;
  logic [1:0]  wrt0, wrt1;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wire [2:0]  ack0_a, ack1_a, rd_en_a, wr_en_a, busy_a;
  wire [31:0] rdata0_a [3];
  wire [31:0] rdata1_a [3];
  wire [31:0] addr_a   [3];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Instance 0: MEM_CYCLES=1 round-robin; 1: MEM_CYCLES=3 fixed; 2: MEM_CYCLES=4 round-robin
  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int MC = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    localparam int FP = (g == 1) ? 1 : 0;

    mem_port_arbiter_if u_m0 ();
    mem_port_arbiter_if u_m1 ();
    logic        mrd_en, mwr_en, bsy;
    logic [31:0] maddr, mwdata, mrdata;
    logic [2:0]  mrdt;
    logic [1:0]  mwrt;

    assign u_m0.req = req0;   assign u_m0.we = we0;     assign u_m0.addr = addr0;
    assign u_m0.wdata = wdata0; assign u_m0.rd_type = rdt0; assign u_m0.wr_type = wrt0;
    assign u_m1.req = req1;   assign u_m1.we = we1;     assign u_m1.addr = addr1;
    assign u_m1.wdata = wdata1; assign u_m1.rd_type = rdt1; assign u_m1.wr_type = wrt1;
    assign mrdata = memf(maddr);

    mem_port_arbiter #(.MEM_CYCLES(MC), .FIXED_PRIO(FP)) u_dut (
      .clk        (clk),
      .rst        (rst_n),
      .m0         (u_m0),
      .m1         (u_m1),
      .mem_rd_en  (mrd_en),
      .mem_wr_en  (mwr_en),
      .mem_addr   (maddr),
      .mem_wr_data(mwdata),
      .mem_rd_type(mrdt),
      .mem_wr_type(mwrt),
      .mem_rd_data(mrdata),
      .busy       (bsy)
    );

    assign ack0_a[g] = u_m0.ack;  assign ack1_a[g] = u_m1.ack;
    assign rd_en_a[g] = mrd_en;   assign wr_en_a[g] = mwr_en;  assign busy_a[g] = bsy;
    assign rdata0_a[g] = u_m0.rdata; assign rdata1_a[g] = u_m1.rdata; assign addr_a[g] = maddr;

    // Transaction-level model: a grant at edge t0 owns the port for edges t0+1..t0+MC+1
    bit          act = 1'b0;
    bit          last = 1'b1;
    bit          sel, we_c;
    int          t0 = 0;
    logic [31:0] a_c, wd_c, rd0, rd1;
    logic [2:0]  rt_c;
    logic [1:0]  wt_c;
    wire win = (req0 && req1) ? ((FP != 0) ? 1'b0 : ~last) : req1;

    always @(posedge clk) begin
      if (!rst_n) begin
        act  <= 1'b0;
        last <= 1'b1;
        rd0  <= '0;
        rd1  <= '0;
      end else if (!act) begin
        if (req0 || req1) begin
          act  <= 1'b1;
          t0   <= cyc;
          sel  <= win;
          last <= win;
          we_c <= win ? we1 : we0;
          a_c  <= win ? addr1 : addr0;
          wd_c <= win ? wdata1 : wdata0;
          rt_c <= win ? rdt1 : rdt0;
          wt_c <= win ? wrt1 : wrt0;
        end
      end else begin
        if (cyc == t0 + MC && !we_c) begin
          if (sel) rd1 <= memf(a_c);
          else     rd0 <= memf(a_c);
        end
        if (cyc == t0 + MC + 1) act <= 1'b0;
      end
    end

    wire acc = act && ((cyc - 1 - t0) < MC);
    wire dn  = act && ((cyc - 1 - t0) == MC);

    always @(negedge clk) begin
      if (cyc > 0) begin
        chk($sformatf("c%0d_busy", g),   32'(bsy),       32'(act));
        chk($sformatf("c%0d_ack0", g),   32'(u_m0.ack),  32'(dn && !sel));
        chk($sformatf("c%0d_ack1", g),   32'(u_m1.ack),  32'(dn && sel));
        chk($sformatf("c%0d_rd_en", g),  32'(mrd_en),    32'(acc && !we_c));
        chk($sformatf("c%0d_wr_en", g),  32'(mwr_en),    32'(acc && we_c));
        chk($sformatf("c%0d_excl", g),   32'(mrd_en && mwr_en), 32'd0);
        chk($sformatf("c%0d_addr", g),   maddr,          acc ? a_c : 32'd0);
        chk($sformatf("c%0d_wdata", g),  mwdata,         acc ? wd_c : 32'd0);
        chk($sformatf("c%0d_rdt", g),    32'(mrdt),      acc ? 32'(rt_c) : 32'd0);
        chk($sformatf("c%0d_wrt", g),    32'(mwrt),      acc ? 32'(wt_c) : 32'd0);
        chk($sformatf("c%0d_rdata0", g), u_m0.rdata,     rd0);
        chk($sformatf("c%0d_rdata1", g), u_m1.rdata,     rd1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n0, n1m0, k1m1, wrcnt, rdcnt, ackk, nack, nack1, nack2;
    int kk0 [3];
    logic [2:0] who0;

    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; rdt0 = 0; wrt0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; rdt1 = 0; wrt1 = 0;
    step(3);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_acks", 32'(ack0_a | ack1_a), 32'd0);
    chk("rst_en", 32'(rd_en_a | wr_en_a), 32'd0);
    chk("rst_rdata", rdata0_a[0] | rdata1_a[2], 32'd0);
    chk("rst_addr", addr_a[2], 32'd0);
    rst_n = 1'b1;
    step(1);

    // Single m0 read at 0x100
    req0 = 1; we0 = 0; addr0 = 32'h100; rdt0 = 3'd2;
    step(1);
    chk("rd_en_first", 32'(rd_en_a), 32'h7);
    chk("rd_wr_en_first", 32'(wr_en_a), 32'h0);
    req0 = 0;
    step(1);
    chk("rd_ack0_c0", 32'(ack0_a), 32'h1);
    chk("rd_rdata_c0", rdata0_a[0], 32'hDEADBEEF);
    chk("rd_ack1_none", 32'(ack1_a), 32'h0);
    step(6);
    chk("rd_rdata_c1", rdata0_a[1], 32'hDEADBEEF);
    chk("rd_rdata_c2", rdata0_a[2], 32'hDEADBEEF);

    // m1 write: MEM_CYCLES=3 instance holds wr_en for exactly three cycles
    req1 = 1; we1 = 1; addr1 = 32'h200; wdata1 = 32'h12345678; wrt1 = 2'd2;
    wrcnt = 0; rdcnt = 0; ackk = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      if (k == 1) begin
        req1 = 0;
        chk("wr_addr_c1", addr_a[1], 32'h200);
      end
      if (wr_en_a[1]) wrcnt++;
      if (rd_en_a[1]) rdcnt++;
      if (ack1_a[1]) ackk = k;
    end
    chk("wr_cycles_c1", wrcnt, 32'd3);
    chk("wr_no_rd_c1", rdcnt, 32'd0);
    chk("wr_ack_k_c1", ackk, 32'd4);

    // Both requesting: round-robin alternates, fixed priority starves m1
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'hA5A50001; wrt1 = 2'd1;
    n0 = 0; who0 = '0; n1m0 = 0; k1m1 = 0;
    for (int k = 1; k <= 28; k++) begin
      step(1);
      if ((ack0_a[0] || ack1_a[0]) && n0 < 3) begin
        who0[n0] = ack1_a[0];
        kk0[n0] = k;
        n0++;
      end
      if (ack0_a[1] && k1m1 == 0) n1m0++;
      if (ack1_a[1] && k1m1 == 0) k1m1 = k;
      if (k == 16) req0 = 0;
    end
    req1 = 0;
    chk("rr_order_c0", 32'(who0), 32'b010);
    chk("rr_k0_c0", kk0[0], 32'd2);
    chk("rr_k1_c0", kk0[1], 32'd5);
    chk("rr_k2_c0", kk0[2], 32'd8);
    chk("fp_m0_wins_c1", n1m0, 32'd4);
    chk("fp_m1_k_c1", k1m1, 32'd24);
    step(12);

    // Reset mid-ACCESS on the MEM_CYCLES=4 instance
    req1 = 1; we1 = 1; addr1 = 32'h300; wdata1 = 32'hCAFEF00D; wrt1 = 2'd1;
    step(2);
    chk("rstmid_wr_before", 32'(wr_en_a[2]), 32'd1);
    rst_n = 0; req1 = 0;
    step(1);
    chk("rstmid_wr_en", 32'(wr_en_a), 32'd0);
    chk("rstmid_busy", 32'(busy_a), 32'd0);
    chk("rstmid_ack", 32'(ack0_a | ack1_a), 32'd0);
    rst_n = 1;
    step(1);
    chk("rstmid_noack", 32'(ack1_a[2]), 32'd0);
    req1 = 1; we1 = 0; addr1 = 32'h304;
    ackk = 0; nack = 0;
    for (int k = 5; k <= 14; k++) begin
      step(1);
      if (k == 5) req1 = 0;
      if (ack1_a[2]) begin
        nack++;
        ackk = k;
      end
    end
    chk("post_rst_nack_c2", nack, 32'd1);
    chk("post_rst_k_c2", ackk, 32'd9);
    chk("post_rst_rdata_c2", rdata1_a[2], 32'h0304FCFB);

    // Input changes after capture are ignored
    req0 = 1; we0 = 0; addr0 = 32'h400;
    nack1 = 0; nack2 = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (k == 1) begin
        addr0 = 32'h500;
        req0 = 0;
      end
      if (k == 2) begin
        chk("hold_addr_c1", addr_a[1], 32'h400);
        chk("hold_addr_c2", addr_a[2], 32'h400);
      end
      if (ack0_a[1]) nack1++;
      if (ack0_a[2]) nack2++;
    end
    chk("hold_nack_c1", nack1, 32'd1);
    chk("hold_nack_c2", nack2, 32'd1);
    chk("hold_rdata_c1", rdata0_a[1], 32'h0400FBFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
